// File: rtl/uart_prog_loader_pkg.sv
// Shared command codes and state encodings for the serial program loader.
package uart_prog_pkg;

    localparam logic [7:0] CMD_SETADR = 8'h41;
    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_CLRERR = 8'h43;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAITHI
    } rx_state_t;

    typedef enum logic [2:0] {
        P_CMD,
        P_ADR,
        P_LEN,
        P_DATA,
        P_SUM
    } prot_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Program-memory write port: valid/ready handshake with word address and data.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              mem_ready;

    modport master (output mem_adr, output mem_data, output mem_we, input mem_ready);
    modport slave  (input mem_adr, input mem_data, input mem_we, output mem_ready);
endinterface

// File: rtl/uart_prog_loader_rx_core.sv
// 8N1 UART receiver sampled in the clk domain; emits one-cycle byte/frame-error pulses.
module uart_rx_core
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick;

    assign tick = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            state      <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            // Timed states count down and act when the counter reaches 1.
            if (state != R_IDLE && state != R_WAITHI && !tick)
                cnt <= cnt - CNT_W'(1);
            case (state)
                R_IDLE: begin
                    if (!rx_sync) begin
                        state <= R_START;
                        cnt   <= CNT_W'(CLKS_PER_BIT / 2);
                    end
                end
                R_START: begin
                    if (tick) begin
                        if (!rx_sync) begin
                            state   <= R_DATA;
                            cnt     <= CNT_W'(CLKS_PER_BIT);
                            bit_idx <= '0;
                        end else begin
                            state <= R_IDLE;
                        end
                    end
                end
                R_DATA: begin
                    if (tick) begin
                        shreg <= {rx_sync, shreg[7:1]};
                        cnt   <= CNT_W'(CLKS_PER_BIT);
                        if (bit_idx == 3'd7)
                            state <= R_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                R_STOP: begin
                    if (tick) begin
                        if (rx_sync) begin
                            data_byte  <= shreg;
                            byte_valid <= 1'b1;
                            state      <= R_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= R_WAITHI;
                        end
                    end
                end
                R_WAITHI: begin
                    if (rx_sync)
                        state <= R_IDLE;
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: UART command decoder writing little-endian words to memory.
// Optional checksum byte after each burst is enabled by UART_PROG_LOADER_CHECKSUM_EN.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 21,
    parameter int WORD_BYTES   = 1,
    parameter int ADDR_BYTES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    uart_prog_loader_if.master  mem_if,
    output logic                busy,
    output logic                done,
    output logic                err_frame,
    output logic                err_overrun,
    output logic                err_sum
);
    localparam int DATA_W   = 8 * WORD_BYTES;
    localparam int ADR_SH_W = 8 * ADDR_BYTES;
    localparam int IDX_W    = 4;

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ferr;
    logic                hold_full;
    logic [7:0]          hold_byte;
    prot_state_t         pstate;
    logic [ADDR_W-1:0]   next_adr;
    logic [ADR_SH_W-1:0] adr_sh;
    logic [DATA_W-1:0]   word_sh;
    logic [IDX_W-1:0]    byte_idx;
    logic [7:0]          words_left;
    logic                consume;
    logic                accept;
    logic [ADR_SH_W+7:0] adr_cat;
    logic [DATA_W+7:0]   word_cat;
    logic [ADR_SH_W-1:0] adr_next_sh;
    logic [DATA_W-1:0]   word_next_sh;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    logic [7:0]          sum;
`endif

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_byte  (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    // Little-endian assembly: each new byte enters at the top and shifts down.
    assign adr_cat      = {hold_byte, adr_sh};
    assign word_cat     = {hold_byte, word_sh};
    assign adr_next_sh  = adr_cat[ADR_SH_W+7:8];
    assign word_next_sh = word_cat[DATA_W+7:8];

    assign consume = hold_full && !mem_if.mem_we;
    assign accept  = mem_if.mem_we && mem_if.mem_ready;
    assign busy    = (pstate != P_CMD) || mem_if.mem_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_byte <= '0;
        end else begin
            if (consume)
                hold_full <= 1'b0;
            if (rx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_byte <= rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate          <= P_CMD;
            next_adr        <= '0;
            adr_sh          <= '0;
            word_sh         <= '0;
            byte_idx        <= '0;
            words_left      <= '0;
            mem_if.mem_we   <= 1'b0;
            mem_if.mem_adr  <= '0;
            mem_if.mem_data <= '0;
            done            <= 1'b0;
            err_frame       <= 1'b0;
            err_overrun     <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            err_sum         <= 1'b0;
            sum             <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (consume) begin
                case (pstate)
                    P_CMD: begin
                        byte_idx <= '0;
                        case (hold_byte)
                            CMD_SETADR: pstate <= P_ADR;
                            CMD_WRITE:  pstate <= P_LEN;
                            CMD_CLRERR: begin
                                err_frame   <= 1'b0;
                                err_overrun <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                                err_sum     <= 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                    P_ADR: begin
                        adr_sh <= adr_next_sh;
                        if (byte_idx == IDX_W'(ADDR_BYTES - 1)) begin
                            next_adr <= adr_next_sh[ADDR_W-1:0];
                            byte_idx <= '0;
                            pstate   <= P_CMD;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                    P_LEN: begin
                        words_left <= hold_byte;
                        byte_idx   <= '0;
                        pstate     <= P_DATA;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                        sum        <= hold_byte;
`endif
                    end
                    P_DATA: begin
                        word_sh <= word_next_sh;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                        sum     <= sum + hold_byte;
`endif
                        if (byte_idx == IDX_W'(WORD_BYTES - 1)) begin
                            mem_if.mem_we   <= 1'b1;
                            mem_if.mem_adr  <= next_adr;
                            mem_if.mem_data <= word_next_sh;
                            byte_idx        <= '0;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                    P_SUM: begin
                        if (hold_byte != sum)
                            err_sum <= 1'b1;
                        done   <= 1'b1;
                        pstate <= P_CMD;
                    end
`endif
                    default: pstate <= P_CMD;
                endcase
            end
            // Consumption is blocked while a write is pending, so this never collides with the case above.
            if (accept) begin
                mem_if.mem_we <= 1'b0;
                next_adr      <= next_adr + ADDR_W'(1);
                if (words_left == 8'd0) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                    pstate <= P_SUM;
`else
                    pstate <= P_CMD;
                    done   <= 1'b1;
`endif
                end else begin
                    words_left <= words_left - 8'd1;
                end
            end
            if (rx_ferr)
                err_frame <= 1'b1;
            if (rx_valid && hold_full)
                err_overrun <= 1'b1;
        end
    end

`ifndef UART_PROG_LOADER_CHECKSUM_EN
    assign err_sum = 1'b0;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: directed UART command streams, queued expected writes.
module tb_uart_prog_loader;

    localparam int CPB = 4;
    localparam int AW  = 21;
    localparam int WB  = 2;
    localparam int AB  = 3;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    localparam logic [7:0] EXTRA = 8'h33;
`else
    localparam logic [7:0] EXTRA = 8'hAA;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic busy, done, err_frame, err_overrun, err_sum;

    uart_prog_loader_if #(.ADDR_W(AW), .DATA_W(8*WB)) mif();

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .WORD_BYTES   (WB),
        .ADDR_BYTES   (AB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .mem_if      (mif),
        .busy        (busy),
        .done        (done),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .err_sum     (err_sum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   adr;
        logic [8*WB-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pay[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every cycle a write is offered it must match the queue head; pop on acceptance.
    always @(negedge clk) begin
        if (!reset) begin
            if (mif.mem_we) begin
                if (exp_q.size() == 0) begin
                    check("write_without_expectation", 32'(mif.mem_we), 32'd0);
                end else begin
                    check("wr_adr", 32'(mif.mem_adr), 32'(exp_q[0].adr));
                    check("wr_data", 32'(mif.mem_data), 32'(exp_q[0].data));
                    if (mif.mem_ready)
                        void'(exp_q.pop_front());
                end
            end
            if (done)
                done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(2*CPB);
    endtask

    task automatic send_setadr(input logic [23:0] a);
        send_byte(8'h41, 1'b1);
        send_byte(a[7:0], 1'b1);
        send_byte(a[15:8], 1'b1);
        send_byte(a[23:16], 1'b1);
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [8*WB-1:0] d);
        wr_t e;
        e.adr  = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Queues the expected words from pay[], then sends WRITE, len, payload (and checksum).
    task automatic send_burst(input logic [AW-1:0] start, input logic [7:0] len,
                              input logic glitch, input logic [7:0] sum_adj);
        logic [7:0]      s;
        logic [8*WB-1:0] d;
        for (int w = 0; w <= int'(len); w++) begin
            d = '0;
            for (int b = 0; b < WB; b++)
                d[8*b +: 8] = pay[w*WB + b];
            push_exp(start + AW'(w), d);
        end
        send_byte(8'h57, 1'b1);
        if (glitch) begin
            rx = 1'b0;
            tick(1);
            rx = 1'b1;
            tick(4*CPB);
        end
        send_byte(len, 1'b1);
        s = len;
        foreach (pay[i]) begin
            send_byte(pay[i], 1'b1);
            s = s + pay[i];
        end
        s = s + sum_adj;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        send_byte(s, 1'b1);
`endif
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !busy)
                break;
            tick(1);
        end
        tick(2);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        mif.mem_ready = 1'b1;
        reset = 1'b1;
        tick(3);
        check("rst_we", 32'(mif.mem_we), 32'd0);
        check("rst_adr", 32'(mif.mem_adr), 32'd0);
        check("rst_data", 32'(mif.mem_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", {29'd0, err_frame, err_overrun, err_sum}, 32'd0);
        reset = 1'b0;
        tick(2*CPB);

        // Basic two-word burst.
        send_setadr(24'h000010);
        pay = '{8'h34, 8'h12, 8'h78, 8'h56};
        send_burst(21'h000010, 8'h01, 1'b0, 8'h00);
        wait_idle("basic");
        check("basic_done", 32'(done_cnt), 32'd1);

        // Address wrap at the top of the word space.
        send_setadr(24'h1FFFFF);
        pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_burst(21'h1FFFFF, 8'h01, 1'b0, 8'h00);
        wait_idle("wrap");
        check("wrap_done", 32'(done_cnt), 32'd2);

        // Stalled write, held byte, overrun, then CLRERR.
        send_setadr(24'h000020);
        push_exp(21'h000020, 16'h2211);
        mif.mem_ready = 1'b0;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("stall_we", 32'(mif.mem_we), 32'd1);
        send_byte(EXTRA, 1'b1);
        check("stall_no_ovr_yet", 32'(err_overrun), 32'd0);
        send_byte(8'hBB, 1'b1);
        check("stall_overrun", 32'(err_overrun), 32'd1);
        check("stall_we_held", 32'(mif.mem_we), 32'd1);
        mif.mem_ready = 1'b1;
        wait_idle("stall");
        check("stall_done", 32'(done_cnt), 32'd3);
        check("stall_sum_ok", 32'(err_sum), 32'd0);
        check("ovr_sticky", 32'(err_overrun), 32'd1);
        send_byte(8'h43, 1'b1);
        check("clrerr_ovr", 32'(err_overrun), 32'd0);

        // Framing error, then a glitch inside a valid burst.
        send_byte(8'h55, 1'b0);
        check("frame_err", 32'(err_frame), 32'd1);
        check("frame_busy", 32'(busy), 32'd0);
        send_setadr(24'h000040);
        pay = '{8'h55, 8'hAA};
        send_burst(21'h000040, 8'h00, 1'b1, 8'h00);
        wait_idle("after_frame");
        check("after_frame_done", 32'(done_cnt), 32'd4);
        check("frame_sticky", 32'(err_frame), 32'd1);

        // Reset in the middle of a data bit.
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB + 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midbit_we", 32'(mif.mem_we), 32'd0);
        check("midbit_adr", 32'(mif.mem_adr), 32'd0);
        check("midbit_errs", {29'd0, err_frame, err_overrun, err_sum}, 32'd0);
        check("midbit_busy", 32'(busy), 32'd0);
        tick(2*CPB);

        // Reset while a write is pending, then a clean burst from address 0.
        send_setadr(24'h000100);
        push_exp(21'h000100, 16'h3412);
        mif.mem_ready = 1'b0;
        send_byte(8'h57, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("pend_we", 32'(mif.mem_we), 32'd1);
        reset = 1'b1;
        tick(1);
        exp_q.delete();
        reset = 1'b0;
        check("pendrst_we", 32'(mif.mem_we), 32'd0);
        check("pendrst_adr", 32'(mif.mem_adr), 32'd0);
        check("pendrst_data", 32'(mif.mem_data), 32'd0);
        check("pendrst_busy", 32'(busy), 32'd0);
        mif.mem_ready = 1'b1;
        tick(2*CPB);
        pay = '{8'hCD, 8'hAB};
        send_burst(21'h000000, 8'h00, 1'b0, 8'h00);
        wait_idle("post_rst");
        check("post_rst_done", 32'(done_cnt), 32'd5);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
        pay = '{8'h01, 8'h02};
        send_burst(21'h000001, 8'h00, 1'b0, 8'h00);
        wait_idle("sum_ok");
        check("sum_ok_err", 32'(err_sum), 32'd0);
        check("sum_ok_done", 32'(done_cnt), 32'd6);
        send_burst(21'h000002, 8'h00, 1'b0, 8'h01);
        wait_idle("sum_bad");
        check("sum_bad_err", 32'(err_sum), 32'd1);
        check("sum_bad_done", 32'(done_cnt), 32'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
